// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and enums for the UART frame controller
//
// Purpose : SYNC byte value, frame FSM state enum and abort-cause enum.
// Ports   : none (package).
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_LENGTH   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte timeout counter
//
// Purpose : counts clk cycles since the last clear while enabled and flags
//           the cycle in which the count reaches TIMEOUT_CYCLES-1.
// Ports   : clk     - clock
//           rst     - synchronous active-high reset
//           enable  - count while high (frame in progress)
//           clear   - restart the count (byte received or not in a frame)
//           expired - one-cycle timeout indication (combinational)
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires in the cycle whose edge moves the count to TIMEOUT_CYCLES-1; the
  // caller registers the abort on that edge, so the error pulse appears
  // exactly TIMEOUT_CYCLES cycles after the strobe that cleared the count.
  // A clear in the same cycle (byte arriving) suppresses it.
  assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - UART byte-stream frame parser with checksum and timeout
//
// Purpose : parses SYNC, CMD, LEN, payload, CHK frames from a byte strobe
//           stream, writes payload bytes out, and reports pass/abort.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           next_byte_i       - one-cycle received-byte strobe
//           data_i            - received byte
//           wr_en_o           - payload write strobe
//           wr_addr_o         - payload byte index
//           wr_data_o         - payload byte
//           frame_valid_o     - checksum passed pulse
//           frame_error_o     - frame aborted pulse
//           err_code_o        - cause of the last abort
//           cmd_o, len_o      - CMD / LEN of current or last frame
//           busy_o            - frame in progress
//           dropped_count_o   - saturating count of non-SYNC bytes in IDLE
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       next_byte_i,
  input  logic [7:0] data_i,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       frame_valid_o,
  output logic       frame_error_o,
  output logic [1:0] err_code_o,
  output logic [7:0] cmd_o,
  output logic [7:0] len_o,
  output logic       busy_o,
  output logic [7:0] dropped_count_o
);

  state_e     state_q, state_d;
  logic       busy;
  logic       timeout;

  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  err_e       err_code_q, err_code_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] dropped_q, dropped_d;

  assign busy = (state_q != ST_IDLE);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (busy),
    .clear  (next_byte_i || !busy),
    .expired(timeout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a byte always takes priority over a coincident timeout
  always_comb begin
    state_d = state_q;
    if (next_byte_i) begin
      case (state_q)
        ST_IDLE:    if (data_i == SYNC_BYTE) state_d = ST_CMD;
        ST_CMD:     state_d = ST_LEN;
        ST_LEN: begin
          if (data_i > 8'(MAX_LEN))  state_d = ST_IDLE;
          else if (data_i == 8'd0)   state_d = ST_CHK;
          else                       state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: if (idx_q == len_q - 8'd1) state_d = ST_CHK;
        ST_CHK:     state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // Output / datapath next values; everything is registered for 1-cycle latency
  always_comb begin
    wr_en_d    = 1'b0;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    dropped_d  = dropped_q;
    if (next_byte_i) begin
      case (state_q)
        ST_IDLE: begin
          if (data_i != SYNC_BYTE && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
        end
        ST_CMD: begin
          cmd_d = data_i;
          chk_d = data_i;
        end
        ST_LEN: begin
          len_d = data_i;
          chk_d = chk_q ^ data_i;
          idx_d = 8'd0;
          if (data_i > 8'(MAX_LEN)) begin
            error_d    = 1'b1;
            err_code_d = ERR_LENGTH;
          end
        end
        ST_PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = data_i;
          chk_d     = chk_q ^ data_i;
          idx_d     = idx_q + 8'd1;
        end
        ST_CHK: begin
          if (data_i == chk_q) begin
            valid_d = 1'b1;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CHECKSUM;
          end
        end
        default: ;
      endcase
    end else if (timeout) begin
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      cmd_q      <= 8'd0;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      chk_q      <= 8'd0;
      dropped_q  <= 8'd0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      dropped_q  <= dropped_d;
    end
  end

  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign frame_valid_o   = valid_q;
  assign frame_error_o   = error_q;
  assign err_code_o      = err_code_q;
  assign cmd_o           = cmd_q;
  assign len_o           = len_q;
  assign busy_o          = busy;
  assign dropped_count_o = dropped_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - self-checking bench for uart_frame_ctrl
module tb_uart_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TO      = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       next_byte = 1'b0;
  logic [7:0] data = 8'd0;
  logic       wr_en, frame_valid, frame_error, busy;
  logic [7:0] wr_addr, wr_data, cmd, len, dropped_count;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .next_byte_i    (next_byte),
    .data_i         (data),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .frame_valid_o  (frame_valid),
    .frame_error_o  (frame_error),
    .err_code_o     (err_code),
    .cmd_o          (cmd),
    .len_o          (len),
    .busy_o         (busy),
    .dropped_count_o(dropped_count)
  );

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  bit chk_on = 0;

  // Behavioural model: frame held as a byte queue after SYNC
  bit         m_in_frame = 0;
  logic [7:0] m_q[$];
  int         cyc = 0;
  int         last_strobe = 0;
  logic       exp_wr_en = 0, exp_valid = 0, exp_error = 0;
  logic [7:0] exp_wr_addr = 0, exp_wr_data = 0, exp_cmd = 0, exp_len = 0, exp_dropped = 0;
  logic [1:0] exp_err_code = 0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_step(input bit r, input bit nb, input logic [7:0] d);
    logic [7:0] x;
    int n;
    exp_wr_en = 0;
    exp_valid = 0;
    exp_error = 0;
    cyc++;
    if (r) begin
      m_in_frame = 0;
      m_q.delete();
      exp_wr_addr = 0; exp_wr_data = 0; exp_cmd = 0; exp_len = 0;
      exp_dropped = 0; exp_err_code = 0;
      return;
    end
    if (nb) begin
      last_strobe = cyc;
      if (!m_in_frame) begin
        if (d == 8'hA5) begin
          m_in_frame = 1;
          m_q.delete();
        end else if (exp_dropped != 8'hFF) begin
          exp_dropped = exp_dropped + 8'd1;
        end
      end else begin
        m_q.push_back(d);
        n = m_q.size();
        if (n == 1) begin
          exp_cmd = d;
        end else if (n == 2) begin
          exp_len = d;
          if (int'(d) > MAX_LEN) begin
            exp_error = 1; exp_err_code = 2; m_in_frame = 0;
          end
        end else if (n <= int'(exp_len) + 2) begin
          exp_wr_en = 1; exp_wr_addr = 8'(n - 3); exp_wr_data = d;
        end else begin
          x = 0;
          for (int i = 0; i < n - 1; i++) x = x ^ m_q[i];
          if (x == d) exp_valid = 1;
          else begin exp_error = 1; exp_err_code = 1; end
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame && (cyc - last_strobe) == TO - 1) begin
      exp_error = 1; exp_err_code = 3; m_in_frame = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("wr_en", {7'd0, wr_en}, {7'd0, exp_wr_en});
      cmp("wr_addr", wr_addr, exp_wr_addr);
      cmp("wr_data", wr_data, exp_wr_data);
      cmp("frame_valid", {7'd0, frame_valid}, {7'd0, exp_valid});
      cmp("frame_error", {7'd0, frame_error}, {7'd0, exp_error});
      cmp("err_code", {6'd0, err_code}, {6'd0, exp_err_code});
      cmp("cmd", cmd, exp_cmd);
      cmp("len", len, exp_len);
      cmp("busy", {7'd0, busy}, {7'd0, m_in_frame});
      cmp("dropped_count", dropped_count, exp_dropped);
    end
  end

  task automatic cycle(input bit r, input bit nb, input logic [7:0] d);
    rst = r;
    next_byte = nb;
    data = d;
    @(posedge clk);
    model_step(r, nb, d);
    #1;
    if (wr_en === 1'b1) wr_cnt++;
    chk_on = 1;
  endtask

  task automatic send(input logic [7:0] d);
    cycle(0, 1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'd0);
  endtask

  initial begin
    int w0, k;
    bit seen;
    logic [7:0] fr[$];
    logic [7:0] x;
    int flen, g;

    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cmp("rst_busy", {7'd0, busy}, 8'd0);
    cmp("rst_wr_en", {7'd0, wr_en}, 8'd0);
    cmp("rst_err_code", {6'd0, err_code}, 8'd0);
    cmp("rst_dropped", dropped_count, 8'd0);
    cycle(0, 0, 0);

    // Dropped bytes then zero-length frame
    send(8'h00); send(8'hFF);
    cmp("drop2", dropped_count, 8'd2);
    cmp("model_drop2", exp_dropped, 8'd2);
    w0 = wr_cnt;
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
    cmp("z_valid", {7'd0, frame_valid}, 8'd1);
    cmp("z_cmd", cmd, 8'h07);
    cmp("z_len", len, 8'h00);
    idle(1);
    cmp("z_writes", 8'(wr_cnt - w0), 8'd0);

    // Good frame
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10);
    cmp("g_wr0_en", {7'd0, wr_en}, 8'd1);
    cmp("g_wr0_addr", wr_addr, 8'd0);
    cmp("g_wr0_data", wr_data, 8'h10);
    send(8'h20);
    cmp("g_wr1_addr", wr_addr, 8'd1);
    cmp("g_wr1_data", wr_data, 8'h20);
    send(8'h33);
    cmp("g_valid", {7'd0, frame_valid}, 8'd1);
    cmp("g_noerr", {7'd0, frame_error}, 8'd0);
    cmp("g_cmd", cmd, 8'h01);
    cmp("g_len", len, 8'h02);
    cmp("model_g_valid", {7'd0, exp_valid}, 8'd1);

    // Bad checksum
    w0 = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h34);
    cmp("c_err", {7'd0, frame_error}, 8'd1);
    cmp("c_code", {6'd0, err_code}, 8'd1);
    cmp("c_novalid", {7'd0, frame_valid}, 8'd0);
    idle(1);
    cmp("c_writes", 8'(wr_cnt - w0), 8'd2);

    // Oversize length
    w0 = wr_cnt;
    send(8'hA5); send(8'h05); send(8'h11);
    cmp("l_err", {7'd0, frame_error}, 8'd1);
    cmp("l_code", {6'd0, err_code}, 8'd2);
    cmp("l_busy", {7'd0, busy}, 8'd0);
    idle(2);
    cmp("l_writes", 8'(wr_cnt - w0), 8'd0);

    // Timeout measured in cycles from the AA strobe cycle
    send(8'hA5); send(8'h01); send(8'h03); send(8'hAA);
    k = 0; seen = 0;
    while (!seen && k < 3 * TO) begin
      idle(1);
      k++;
      if (frame_error === 1'b1) seen = 1;
    end
    cmp("t_seen", {7'd0, seen}, 8'd1);
    cmp("t_latency", 8'(k + 1), 8'(TO));
    cmp("t_code", {6'd0, err_code}, 8'd3);
    send(8'hA5);
    cmp("t_restart_busy", {7'd0, busy}, 8'd1);
    send(8'h01); send(8'h00); send(8'h01);
    cmp("t_restart_valid", {7'd0, frame_valid}, 8'd1);

    // Byte coinciding with the timeout wins
    send(8'hA5);
    idle(TO - 2);
    send(8'h01);
    cmp("co_noerr", {7'd0, frame_error}, 8'd0);
    cmp("co_busy", {7'd0, busy}, 8'd1);
    send(8'h00); send(8'h01);
    cmp("co_valid", {7'd0, frame_valid}, 8'd1);

    // Reset mid-frame
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10);
    cycle(1, 0, 0);
    cmp("r_wr_en", {7'd0, wr_en}, 8'd0);
    cmp("r_busy", {7'd0, busy}, 8'd0);
    cmp("r_err", {7'd0, frame_error}, 8'd0);
    cmp("r_code", {6'd0, err_code}, 8'd0);
    cmp("r_cmd", cmd, 8'd0);
    cmp("r_len", len, 8'd0);
    cmp("r_addr", wr_addr, 8'd0);
    cmp("r_data", wr_data, 8'd0);
    cmp("r_drop", dropped_count, 8'd0);
    cycle(0, 0, 0);
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    cmp("r_valid", {7'd0, frame_valid}, 8'd1);

    // Randomized traffic against the model
    for (int f = 0; f < 300; f++) begin
      case ($urandom_range(0, 11))
        0: for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
             send(8'($urandom));
             idle($urandom_range(0, 2));
           end
        1: cycle(1, 0, 0);
        default: begin
          fr.delete();
          flen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAX_LEN + 1, 255))
                                              : int'($urandom_range(0, MAX_LEN));
          fr.push_back(8'($urandom));
          fr.push_back(8'(flen));
          if (flen <= MAX_LEN) begin
            for (int j = 0; j < flen; j++)
              fr.push_back(($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom));
            x = 0;
            foreach (fr[j]) x = x ^ fr[j];
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            fr.push_back(x);
          end
          send(8'hA5);
          foreach (fr[j]) begin
            if ($urandom_range(0, 19) == 0) g = TO - 3 + int'($urandom_range(0, 2));
            else g = int'($urandom_range(0, 2));
            idle(g);
            send(fr[j]);
          end
          idle($urandom_range(0, 3));
        end
      endcase
    end
    idle(TO + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter: MAX_LEN, 16, largest legal payload length in bytes (1..255).
REQ-002 Parameter: TIMEOUT_CYCLES, 100000, allowed clk cycles between bytes inside a frame.
REQ-003 Port: clk  input  1  clock; all logic on posedge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: next_byte  input  1  one-cycle strobe from the UART receiver; data valid this cycle.
REQ-006 Port: data  input  8  received byte.
REQ-007 Port: wr_en  output  1  payload write strobe, one cycle per payload byte.
REQ-008 Port: wr_addr  output  8  payload byte index, 0..LEN-1.
REQ-009 Port: wr_data  output  8  payload byte.
REQ-010 Port: frame_valid  output  1  one-cycle pulse when a frame passes its checksum.
REQ-011 Port: frame_error  output  1  one-cycle pulse when a frame is aborted.
REQ-012 Port: err_code  output  2  cause of the last abort; held until the next abort.
REQ-013 Port: cmd  output  8  CMD byte of the current or last frame.
REQ-014 Port: len  output  8  LEN byte of the current or last frame.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: dropped_count  output  8  saturating count of non-SYNC bytes received in IDLE.

Function
REQ-017 Frame format: SYNC (0xA5), CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-018 FSM states: IDLE, CMD, LEN, PAYLOAD, CHK; state changes only on a next_byte cycle or on a timeout.
REQ-019 IDLE: byte 0xA5 -> CMD; any other byte -> stay in IDLE and increment dropped_count, saturating at 0xFF.
REQ-020 CMD: latch the byte into cmd, seed the checksum with it, go to LEN.
REQ-021 LEN: latch len; LEN > MAX_LEN -> error code 2 and go to IDLE; LEN = 0 -> CHK; otherwise -> PAYLOAD with index 0.
REQ-022 PAYLOAD: each byte drives wr_en/wr_addr/wr_data on the cycle after the strobe (1-cycle latency); the index increments; after byte LEN-1 -> CHK.
REQ-023 CHK: match -> frame_valid the cycle after the strobe; mismatch -> error code 1; both go to IDLE.
REQ-024 Timeout: an inter-byte counter clears on every next_byte and counts while busy; reaching TIMEOUT_CYCLES-1 -> error code 3 and IDLE.
REQ-025 next_byte arriving in the same cycle as the timeout: the byte wins, the timeout is suppressed and the counter clears.
REQ-026 An error pulses frame_error for one cycle, one cycle after the cause, and updates err_code; wr_en never asserts for an aborted length.
REQ-027 Payload bytes already written before a checksum or timeout error are not retracted; the consumer qualifies them with frame_valid.
REQ-028 A SYNC byte received in CMD/LEN/PAYLOAD/CHK is treated as data, with no resynchronisation.
REQ-029 frame_valid, frame_error and wr_en are mutually exclusive in any cycle.
REQ-030 There is no backpressure; the consumer must accept wr_en in every cycle.

Reset
REQ-031 rst forces IDLE and clears wr_en, frame_valid, frame_error, busy and the timeout counter.
REQ-032 rst sets err_code, cmd, len, wr_addr, wr_data and dropped_count to 0.
REQ-033 rst asserted mid-frame aborts the frame silently, with no frame_error pulse.

Structure
REQ-034 Package uart_frame_pkg holds SYNC_BYTE = 8'hA5, the state enum and the err_code enum (NONE=0, CHECKSUM=1, LENGTH=2, TIMEOUT=3).
REQ-035 The inter-byte timeout counter is one sub-module, byte_timeout (inputs clk, rst, enable, clear; output expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-036 Bytes A5 01 02 10 20 33 -> wr (0,10), (1,20); frame_valid with cmd=01, len=02; no frame_error.
REQ-037 Bytes A5 01 02 10 20 34 -> both writes occur; frame_error with err_code=1; no frame_valid.
REQ-038 Bytes A5 05 11 (MAX_LEN=16) -> frame_error with err_code=2; no wr_en; busy low afterwards.
REQ-039 Bytes A5 07 00 07 -> frame_valid with cmd=07, len=00; zero writes. Preceding bytes 00 FF -> dropped_count=2.
REQ-040 Bytes A5 01 03 AA, then silence -> frame_error with err_code=3 exactly TIMEOUT_CYCLES cycles after the AA strobe; a following A5 starts a new frame.
REQ-041 rst pulsed after A5 01 02 10 -> all outputs at reset values, no pulses; a following clean frame from REQ-036 passes.
